// File: rtl/pwm_servo.sv
// Hobby-servo PWM generator: two debounced active-low push-buttons step a
// saturating pulse-width setpoint that is applied at each 50 Hz frame boundary.
module pwm_servo #(
  parameter int PERIOD_CYCLES   = 1_000_000,
  parameter int MIN_WIDTH       = 50_000,
  parameter int MAX_WIDTH       = 100_000,
  parameter int CENTER_WIDTH    = 75_000,
  parameter int STEP_WIDTH      = 5_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_inc,
  input  logic pb_dec,
  input  logic enable,
  output logic pwm_out
);

  localparam int CW = $clog2(PERIOD_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CW-1:0] LAST_CNT  = CW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] MIN_W     = CW'(MIN_WIDTH);
  localparam logic [CW-1:0] MAX_W     = CW'(MAX_WIDTH);
  localparam logic [CW-1:0] CENTER_W  = CW'(CENTER_WIDTH);
  localparam logic [CW:0]   MAX_EXT   = (CW+1)'(MAX_WIDTH);
  localparam logic [CW:0]   STEP_EXT  = (CW+1)'(STEP_WIDTH);
  localparam logic [CW:0]   LOW_EXT   = (CW+1)'(MIN_WIDTH + STEP_WIDTH);
  localparam logic [DW-1:0] DB_LIMIT  = DW'(DEBOUNCE_CYCLES);

  // Bit 0 is the increment button, bit 1 the decrement button; 1 = pressed.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    filt_q, filt_d;
  logic [1:0]    prev_q;
  logic [1:0]    strobe;
  logic [DW-1:0] dcnt_q [2];
  logic [DW-1:0] dcnt_d [2];

  logic [CW-1:0] target_q, target_d;
  logic [CW-1:0] width_q, width_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pwm_q, pwm_d;
  logic [CW:0]   tgt_ext, inc_sum, dec_diff;
  logic          frame_wrap;

  assign btn_raw = ~{pb_dec, pb_inc};
  assign strobe  = filt_q & ~prev_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      dcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        // The new level is accepted only after it has already held for the
        // full debounce window, so a shorter pulse never reaches filt_q.
        if (dcnt_q[i] == DB_LIMIT) begin
          filt_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign tgt_ext  = {1'b0, target_q};
  assign inc_sum  = tgt_ext + STEP_EXT;
  assign dec_diff = tgt_ext - STEP_EXT;

  always_comb begin
    target_d = target_q;
    unique case (strobe)
      2'b01:   target_d = (inc_sum > MAX_EXT) ? MAX_W : inc_sum[CW-1:0];
      2'b10:   target_d = (tgt_ext < LOW_EXT) ? MIN_W : dec_diff[CW-1:0];
      default: target_d = target_q;
    endcase
  end

  assign frame_wrap = enable && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d   = '0;
    width_d = width_q;
    if (enable && !frame_wrap) begin
      cnt_d = cnt_q + 1'b1;
    end
    // The active width only follows the setpoint between frames.
    if (!enable || frame_wrap) begin
      width_d = target_q;
    end
    pwm_d = enable && (cnt_q < width_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      filt_q   <= '0;
      prev_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        dcnt_q[i] <= '0;
      end
      target_q <= CENTER_W;
      width_q  <= CENTER_W;
      cnt_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      filt_q   <= filt_d;
      prev_q   <= filt_q;
      for (int i = 0; i < 2; i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
      target_q <= target_d;
      width_q  <= width_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_servo.sv
// Directed bench for pwm_servo with shrunk timing (1000-clock frames, 75-clock
// centre pulse, 1-clock debounce); a pulse monitor measures high time and period.
module tb_pwm_servo;

  logic clk = 1'b0;
  logic rst;
  logic pb_inc;
  logic pb_dec;
  logic enable;
  logic pwm_out;

  int n_cmp = 0;
  int n_err = 0;

  // Pulse monitor state, updated on the falling clock edge.
  logic prev_pwm   = 1'b0;
  int   high_run   = 0;
  int   last_high  = -1;
  int   since_rise = 0;
  int   last_period = -1;
  int   rises      = 0;
  int   falls      = 0;

  pwm_servo #(
    .PERIOD_CYCLES   (1000),
    .MIN_WIDTH       (50),
    .MAX_WIDTH       (100),
    .CENTER_WIDTH    (75),
    .STEP_WIDTH      (5),
    .DEBOUNCE_CYCLES (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pb_inc  (pb_inc),
    .pb_dec  (pb_dec),
    .enable  (enable),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pwm_out === 1'b1 && prev_pwm === 1'b0) begin
      last_period = since_rise;
      since_rise  = 0;
      high_run    = 0;
      rises++;
    end
    if (pwm_out === 1'b1) high_run++;
    if (pwm_out !== 1'b1 && prev_pwm === 1'b1) begin
      last_high = high_run;
      falls++;
    end
    since_rise++;
    prev_pwm = (pwm_out === 1'b1);
  end

  task automatic check(input string tag, input int observed, input int expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_pulse(input string tag);
    int f0 = falls;
    int seen = 0;
    for (int i = 0; i < 3000 && seen == 0; i++) begin
      step(1);
      if (falls > f0) seen = 1;
    end
    check({tag, "_pulse_seen"}, seen, 1);
  endtask

  task automatic wait_rise(input string tag);
    int r0 = rises;
    int seen = 0;
    for (int i = 0; i < 3000 && seen == 0; i++) begin
      step(1);
      if (rises > r0) seen = 1;
    end
    check({tag, "_rise_seen"}, seen, 1);
  endtask

  // Skip the frame that may straddle a setpoint change, then measure a full one.
  task automatic settle_check(input string tag, input int expected);
    wait_pulse(tag);
    wait_pulse(tag);
    check({tag, "_high"}, last_high, expected);
  endtask

  task automatic press(input logic inc, input logic dec, input int hold);
    pb_inc = ~inc;
    pb_dec = ~dec;
    step(hold);
    pb_inc = 1'b1;
    pb_dec = 1'b1;
    step(8);
  endtask

  initial begin
    int highs;
    rst    = 1'b0;
    pb_inc = 1'b1;
    pb_dec = 1'b1;
    enable = 1'b1;

    // Reset: output low throughout, first frame starts right after release.
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("reset_pwm_low", int'(pwm_out === 1'b0), 1);
    end
    rst = 1'b1;
    step(1);
    check("first_frame_start", int'(pwm_out === 1'b1), 1);
    wait_pulse("reset");
    check("reset_first_high", last_high, 75);
    wait_pulse("reset2");
    check("reset_second_high", last_high, 75);
    check("frame_period", last_period, 1000);

    // Single press mid-frame: current frame keeps 75, next one gets 80.
    wait_rise("inc1");
    press(1'b1, 1'b0, 2);
    wait_pulse("inc1_cur");
    check("inc1_current_frame", last_high, 75);
    wait_pulse("inc1_next");
    check("inc1_next_frame", last_high, 80);
    press(1'b0, 1'b1, 2);
    settle_check("dec1", 75);

    // Saturation at both limits.
    for (int i = 0; i < 12; i++) press(1'b1, 1'b0, 2);
    settle_check("sat_max", 100);
    for (int i = 0; i < 15; i++) press(1'b0, 1'b1, 2);
    settle_check("sat_min", 50);
    press(1'b1, 1'b0, 2);
    settle_check("from_min_inc", 55);
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 2);
    settle_check("back_center", 75);

    // One-clock glitches are rejected; a long hold gives exactly one step.
    for (int i = 0; i < 5; i++) begin
      pb_inc = 1'b0;
      step(1);
      pb_inc = 1'b1;
      step(3);
    end
    settle_check("glitch", 75);
    press(1'b1, 1'b0, 200);
    settle_check("hold200", 80);
    press(1'b0, 1'b1, 2);
    settle_check("hold_undo", 75);

    // Both buttons together leave the setpoint alone.
    press(1'b1, 1'b1, 2);
    settle_check("simultaneous", 75);

    // Enable drop mid-high, then re-enable with a full pulse.
    wait_rise("en");
    step(10);
    check("en_mid_high", int'(pwm_out === 1'b1), 1);
    enable = 1'b0;
    step(1);
    check("en_off_next_clk", int'(pwm_out === 1'b0), 1);
    highs = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (pwm_out !== 1'b0) highs++;
    end
    check("en_off_stays_low", highs, 0);
    enable = 1'b1;
    step(1);
    check("en_on_high", int'(pwm_out === 1'b1), 1);
    wait_pulse("en_on");
    check("en_on_full_pulse", last_high, 75);

    // Reset mid-frame aborts the pulse and restores the centre setpoint.
    press(1'b1, 1'b0, 2);
    wait_rise("rst_mid");
    step(10);
    rst = 1'b0;
    step(1);
    check("rst_mid_pwm_low", int'(pwm_out === 1'b0), 1);
    step(3);
    rst = 1'b1;
    step(1);
    check("rst_mid_restart", int'(pwm_out === 1'b1), 1);
    wait_pulse("rst_mid");
    check("rst_mid_center", last_high, 75);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_servo.md
# pwm_servo

Hobby-servo position controller for the arm joint boards. Two active-low push-buttons step a pulse-width setpoint up or down. The block emits a standard 50 Hz servo PWM whose high time tracks that setpoint, saturating at the servo's mechanical limits. It sits between the board push-buttons and the servo signal pin, in the single 50 MHz system clock domain.

## Interface
Parameters:
- PERIOD_CYCLES, 1_000_000: PWM frame length in clocks (20 ms at 50 MHz).
- MIN_WIDTH, 50_000: minimum high time in clocks (1.0 ms).
- MAX_WIDTH, 100_000: maximum high time in clocks (2.0 ms).
- CENTER_WIDTH, 75_000: reset high time in clocks (1.5 ms).
- STEP_WIDTH, 5_000: high-time change per accepted press (0.1 ms).
- DEBOUNCE_CYCLES, 500_000: clocks a button level must stay stable before it is accepted (10 ms).

Ports:
- clk  in  1  system clock, 50 MHz, rising edge.
- rst  in  1  reset; synchronous, active-low.
- pb_inc  in  1  increment button, asynchronous, active-low (pressed = 0).
- pb_dec  in  1  decrement button, asynchronous, active-low (pressed = 0).
- enable  in  1  output enable, active-high.
- pwm_out  out  1  servo PWM, registered.

Constraints:
- MIN_WIDTH ≤ CENTER_WIDTH ≤ MAX_WIDTH < PERIOD_CYCLES.
- Counter widths are $clog2(PERIOD_CYCLES+1) bits.

## Operation
- Button path, per button:
  - Invert the raw input, so 1 = pressed.
  - Pass it through a 2-FF synchronizer.
  - Debounce: the filtered level takes the synchronized value once that value has differed from the filtered level for DEBOUNCE_CYCLES consecutive clocks. Any bounce restarts the count.
  - A press is the 0→1 transition of the filtered level. It yields a one-cycle strobe.
  - Holding a button gives exactly one strobe and no auto-repeat. Release generates nothing.
- Setpoint register `target`:
  - inc strobe alone: target = min(target + STEP_WIDTH, MAX_WIDTH).
  - dec strobe alone: target = max(target − STEP_WIDTH, MIN_WIDTH).
  - Both strobes in the same cycle: target unchanged.
  - All arithmetic is computed one bit wider, so no wrap-around is possible.
  - Buttons are processed regardless of enable.
- Frame counter `cnt`:
  - Counts 0..PERIOD_CYCLES−1 and wraps to 0.
  - While enable = 0, cnt is held at 0.
- Active width `width`: loaded from target only when cnt wraps to 0, or while enable = 0. Changes therefore never alter a frame in progress.
- pwm_out (next) = enable & (cnt < width).
- Reset (rst = 0 at a clock edge):
  - cnt = 0, target = width = CENTER_WIDTH.
  - Synchronizers, filtered levels and debounce counters are cleared to "released".
  - pwm_out = 0.
  - Reset mid-frame aborts the frame immediately.

## Timing
- Frame length is exactly PERIOD_CYCLES clocks. High time per frame is exactly `width` clocks, starting the cycle after cnt = 0.
- Press latency from the pb_x falling edge to the target update: 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) clocks.
- Press latency to the output: the update takes effect at the next frame start.
- Minimum press duration that registers: DEBOUNCE_CYCLES + 1 clocks at the synchronizer output.
- Enable:
  - enable 1→0: pwm_out is 0 on the next clock.
  - enable 0→1: a new frame starts at cnt = 0, and pwm_out is high on the following clock.
- Release of rst: the first frame starts on the clock after rst returns to 1.

## Test plan
Sim parameters: PERIOD_CYCLES=1000, MIN_WIDTH=50, MAX_WIDTH=100, CENTER_WIDTH=75, STEP_WIDTH=5, DEBOUNCE_CYCLES=1, enable=1.

- Reset check:
  - Stimulus: hold rst=0 for 5 clocks, then release.
  - Required: pwm_out=0 during reset; afterwards repeating frames of 1000 clocks with 75 high.
- Single press:
  - Stimulus: pb_inc=0 for 2 clocks (40 ns).
  - Required: high time becomes 80 from the next frame; the current frame stays at 75. Then pb_dec pulse → 75.
- Saturation:
  - Stimulus: 12 separate inc presses.
  - Required: high time stops at 100. Then 15 dec presses → stops at 50; no wrap.
- Bounce and hold:
  - Stimulus: 1-clock glitches on pb_inc produce no change. A 200-clock hold produces exactly one +5 step.
- Simultaneous:
  - Stimulus: pb_inc and pb_dec pulsed together.
  - Required: high time unchanged at 75.
- Enable:
  - Stimulus: drop enable mid-high-phase.
  - Required: pwm_out=0 next clock and stays 0. On re-enable, the high phase restarts with a full 75-clock pulse.
